// File: rtl/motor_cmd_sequencer.sv
//------------------------------------------------------------------------------
// motor_cmd_sequencer
//
// Byte-command sequencer for the gate motor. Bytes arriving from the UART RX
// path are decoded into open/close/stop/status commands. The block drives the
// two motor outputs under limit-switch and timeout supervision. Before any
// motor starts, both outputs are held off for a dead time. One-byte status
// replies are queued to the UART TX path with a start/done handshake.
//
// Ports
//   Clk            in   1  system clock
//   Rst_n          in   1  asynchronous active-low reset
//   RxData         in   8  received byte, valid while RxDone=1
//   RxDone         in   1  one-cycle strobe, byte complete
//   finalcarrera1  in   1  open limit switch, active-high, asynchronous
//   finalcarrera2  in   1  closed limit switch, active-high, asynchronous
//   TxDone         in   1  one-cycle strobe, TX byte sent
//   TxData         out  8  reply byte, stable from tx_start until TxDone
//   tx_start       out  1  one-cycle strobe, launch TxData
//   motor1         out  1  drive open direction
//   motor2         out  1  drive close direction
//   fault          out  1  high while in FAULT
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module motor_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned DEAD_CYC    = 50_000,
  parameter logic [7:0]  CMD_OPEN    = 8'h41,
  parameter logic [7:0]  CMD_CLOSE   = 8'h43,
  parameter logic [7:0]  CMD_STOP    = 8'h53,
  parameter logic [7:0]  CMD_STATUS  = 8'h3F
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] RxData,
  input  logic       RxDone,
  input  logic       finalcarrera1,
  input  logic       finalcarrera2,
  input  logic       TxDone,
  output logic [7:0] TxData,
  output logic       tx_start,
  output logic       motor1,
  output logic       motor2,
  output logic       fault
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DEAD    = 3'd1;
  localparam logic [2:0] ST_OPENING = 3'd2;
  localparam logic [2:0] ST_CLOSING = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  localparam logic DIR_OPEN  = 1'b0;
  localparam logic DIR_CLOSE = 1'b1;

  // Reply bytes
  localparam logic [7:0] RPL_OPEN    = 8'h4F;  // 'O' open limit reached / already open
  localparam logic [7:0] RPL_CLOSE   = 8'h43;  // 'C' closed limit reached / already closed
  localparam logic [7:0] RPL_TMO     = 8'h54;  // 'T' motion timeout
  localparam logic [7:0] RPL_FAULT   = 8'h46;  // 'F' motion refused while faulted
  localparam logic [7:0] RPL_STOP    = 8'h53;  // 'S' stop acknowledged
  localparam logic [7:0] RPL_WIRING  = 8'h45;  // 'E' both limits active
  localparam logic [7:0] STS_IDLE    = 8'h49;  // 'I'
  localparam logic [7:0] STS_DEAD    = 8'h44;  // 'D'
  localparam logic [7:0] STS_OPENING = 8'h6F;  // 'o'
  localparam logic [7:0] STS_CLOSING = 8'h63;  // 'c'
  localparam logic [7:0] STS_FAULT   = 8'h46;  // 'F'

  // Last counter value of each timed phase (counter is 0 on the first cycle)
  localparam logic [31:0] DEAD_LAST = 32'(DEAD_CYC - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);

  logic [2:0]  r_state;
  logic        r_target;
  logic [31:0] r_cnt;
  logic        r_lim1_meta, r_lim1_sync;
  logic        r_lim2_meta, r_lim2_sync;
  logic        r_motor1, r_motor2, r_fault;
  logic        r_tx_busy, r_tx_start;
  logic [7:0]  r_tx_data;
  logic        r_pend_valid;
  logic [7:0]  r_pend_data;

  logic [2:0]  w_next;
  logic        w_target_next;
  logic        w_rep_valid;
  logic [7:0]  w_rep_byte;
  logic [7:0]  w_status_byte;
  logic        w_cmd_open, w_cmd_close, w_cmd_stop, w_cmd_status;
  logic        w_moving, w_tmo_hit, w_dead_done, w_tx_free;

  //----------------------------------------------------------------------------
  // Limit-switch synchronizers: the pins are asynchronous to Clk.
  //----------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) so all registers update
  // from the same pre-edge values; blocking here would collapse the 2-FF chain.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_lim1_meta <= 1'b0;
      r_lim1_sync <= 1'b0;
      r_lim2_meta <= 1'b0;
      r_lim2_sync <= 1'b0;
    end else begin
      r_lim1_meta <= finalcarrera1;
      r_lim1_sync <= r_lim1_meta;
      r_lim2_meta <= finalcarrera2;
      r_lim2_sync <= r_lim2_meta;
    end
  end

  //----------------------------------------------------------------------------
  // Command decode and next-state logic
  //----------------------------------------------------------------------------
  assign w_cmd_open   = RxDone && (RxData == CMD_OPEN);
  assign w_cmd_close  = RxDone && (RxData == CMD_CLOSE);
  assign w_cmd_stop   = RxDone && (RxData == CMD_STOP);
  assign w_cmd_status = RxDone && (RxData == CMD_STATUS);

  assign w_moving    = (r_state == ST_OPENING) || (r_state == ST_CLOSING);
  assign w_tmo_hit   = (r_cnt >= TMO_LAST);
  assign w_dead_done = (r_cnt == DEAD_LAST);

  always_comb begin
    w_status_byte = STS_IDLE;
    case (r_state)
      ST_DEAD:    w_status_byte = STS_DEAD;
      ST_OPENING: w_status_byte = STS_OPENING;
      ST_CLOSING: w_status_byte = STS_CLOSING;
      ST_FAULT:   w_status_byte = STS_FAULT;
      default:    w_status_byte = STS_IDLE;
    endcase
  end

  // Priority: wiring error > limit reached > timeout > STOP > other commands.
  // Any supervision transition discards the command of that cycle.
  always_comb begin
    // NOTE: default every output of a combinational block up front so no
    // path leaves a signal unassigned (which would infer a latch).
    w_next        = r_state;
    w_target_next = r_target;
    w_rep_valid   = 1'b0;
    w_rep_byte    = 8'h00;

    if (r_lim1_sync && r_lim2_sync) begin
      w_next = ST_FAULT;
      // Reported once on entry, not every cycle the wiring fault persists
      if (r_state != ST_FAULT) begin
        w_rep_valid = 1'b1;
        w_rep_byte  = RPL_WIRING;
      end
    end else if (r_state == ST_OPENING && r_lim1_sync) begin
      w_next      = ST_IDLE;
      w_rep_valid = 1'b1;
      w_rep_byte  = RPL_OPEN;
    end else if (r_state == ST_CLOSING && r_lim2_sync) begin
      w_next      = ST_IDLE;
      w_rep_valid = 1'b1;
      w_rep_byte  = RPL_CLOSE;
    end else if (w_moving && w_tmo_hit) begin
      w_next      = ST_FAULT;
      w_rep_valid = 1'b1;
      w_rep_byte  = RPL_TMO;
    end else if (w_cmd_stop) begin
      w_next      = ST_IDLE;
      w_rep_valid = 1'b1;
      w_rep_byte  = RPL_STOP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_open) begin
            if (r_lim1_sync) begin
              w_rep_valid = 1'b1;
              w_rep_byte  = RPL_OPEN;
            end else begin
              w_next        = ST_DEAD;
              w_target_next = DIR_OPEN;
            end
          end else if (w_cmd_close) begin
            if (r_lim2_sync) begin
              w_rep_valid = 1'b1;
              w_rep_byte  = RPL_CLOSE;
            end else begin
              w_next        = ST_DEAD;
              w_target_next = DIR_CLOSE;
            end
          end
        end
        ST_DEAD: begin
          // Motors are already off: a new direction just retargets, the
          // dead time keeps running.
          if (w_cmd_open)  w_target_next = DIR_OPEN;
          if (w_cmd_close) w_target_next = DIR_CLOSE;
          if (w_dead_done)
            w_next = (w_target_next == DIR_OPEN) ? ST_OPENING : ST_CLOSING;
        end
        ST_OPENING: begin
          if (w_cmd_close) begin
            w_next        = ST_DEAD;
            w_target_next = DIR_CLOSE;
          end
        end
        ST_CLOSING: begin
          if (w_cmd_open) begin
            w_next        = ST_DEAD;
            w_target_next = DIR_OPEN;
          end
        end
        ST_FAULT: begin
          if (w_cmd_open || w_cmd_close) begin
            w_rep_valid = 1'b1;
            w_rep_byte  = RPL_FAULT;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end

    // A status request is always answered; it takes the reply slot of the
    // cycle and reports the state held before this cycle's update.
    if (w_cmd_status) begin
      w_rep_valid = 1'b1;
      w_rep_byte  = w_status_byte;
    end
  end

  //----------------------------------------------------------------------------
  // State, phase counter and registered motor outputs
  //----------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= ST_IDLE;
      r_target <= DIR_OPEN;
      r_cnt    <= '0;
      r_motor1 <= 1'b0;
      r_motor2 <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_target <= w_target_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 32'd1;
      // Decoded from the one-hot-exclusive next state, so both motors can
      // never be driven together.
      r_motor1 <= (w_next == ST_OPENING);
      r_motor2 <= (w_next == ST_CLOSING);
      r_fault  <= (w_next == ST_FAULT);
    end
  end

  //----------------------------------------------------------------------------
  // Reply transmitter: one byte in flight plus one pending (latest wins)
  //----------------------------------------------------------------------------
  assign w_tx_free = !r_tx_busy || TxDone;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_tx_busy    <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_pend_valid <= 1'b0;
      r_pend_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      if (w_tx_free) begin
        if (w_rep_valid) begin
          // A fresh reply supersedes anything still pending
          r_tx_start   <= 1'b1;
          r_tx_data    <= w_rep_byte;
          r_tx_busy    <= 1'b1;
          r_pend_valid <= 1'b0;
        end else if (r_pend_valid) begin
          r_tx_start   <= 1'b1;
          r_tx_data    <= r_pend_data;
          r_tx_busy    <= 1'b1;
          r_pend_valid <= 1'b0;
        end else begin
          r_tx_busy <= 1'b0;
        end
      end else if (w_rep_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= w_rep_byte;
      end
    end
  end

  assign TxData   = r_tx_data;
  assign tx_start = r_tx_start;
  assign motor1   = r_motor1;
  assign motor2   = r_motor2;
  assign fault    = r_fault;

endmodule
